// File: rtl/rf_wb_arbiter_pkg.sv
// Shared CPU parameters and write-back arbiter types.
//   CPU_WORD / CPU_REG_LOG / CPU_NGPR : datapath width, register index width, GPR count
//   RF_WB_QDEPTH / RF_WB_STARVE_LIMIT : MUL/DIV result queue depth and starvation threshold
//   wb_src_e                          : which source owns the register-file write port this cycle
package rf_wb_arbiter_pkg;

  localparam int unsigned CPU_WORD           = 32;
  localparam int unsigned CPU_REG_LOG        = 5;
  localparam int unsigned CPU_NGPR           = 1 << CPU_REG_LOG;
  localparam int unsigned RF_WB_QDEPTH       = 2;
  localparam int unsigned RF_WB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_PIPE,
    WB_QUEUE,
    WB_BYPASS
  } wb_src_e;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order queue of MUL/DIV results {rd, data} awaiting a free write-back slot.
//   clk_i, rst_i      : clock, synchronous active-high reset (discards all entries)
//   push_i            : enqueue {push_rd_i, push_data_i} at the tail (caller guarantees not full)
//   pop_i             : dequeue the head (caller guarantees not empty)
//   head_rd_o/_data_o : current head entry
//   count_o           : occupancy; empty_o / full_o derived from it
//   ent_valid_o/rd_o  : per-slot valid and destination taps (slot order, not queue order)
module wb_result_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = RF_WB_QDEPTH,
  parameter int unsigned DW    = CPU_WORD,
  parameter int unsigned AW    = CPU_REG_LOG,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [AW-1:0]       push_rd_i,
  input  logic [DW-1:0]       push_data_i,
  input  logic                pop_i,
  output logic [AW-1:0]       head_rd_o,
  output logic [DW-1:0]       head_data_o,
  output logic [CW-1:0]       count_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [DEPTH-1:0]    ent_valid_o,
  output logic [DEPTH*AW-1:0] ent_rd_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]    rd_mem_q   [DEPTH];
  logic [DW-1:0]    data_mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    rptr_q, wptr_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      // Clear before set: a push can only land in the popped slot when
      // the queue was full, which the caller never allows.
      if (pop_i) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + PW'(1);
      end
      if (push_i) begin
        vld_q[wptr_q] <= 1'b1;
        wptr_q        <= wptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      rd_mem_q[wptr_q]   <= push_rd_i;
      data_mem_q[wptr_q] <= push_data_i;
    end
  end

  always_comb begin
    ent_rd_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_rd_o[i*AW +: AW] = rd_mem_q[i];
    end
  end

  assign head_rd_o   = rd_mem_q[rptr_q];
  assign head_data_o = data_mem_q[rptr_q];
  assign count_o     = cnt_q;
  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == DEPTH_C);
  assign ent_valid_o = vld_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port between pipeline WB (always wins,
// never back-pressured) and the MUL/DIV unit, whose results are queued in order
// and drained in idle WB cycles or bypassed straight through when nothing waits.
//   clk, rst                        : clock, synchronous active-high reset
//   pipe_we/pipe_rd/pipe_data       : pipeline write-back request
//   md_valid/md_ready/md_rd/md_data : MUL/DIV result handshake
//   rf_we/rf_waddr/rf_wdata         : register-file write port (combinational)
//   stall_req                       : front-end freeze request when the queue head starves
//   pend_mask                       : destinations of queued results, for decode hazards
//   q_count                         : queue occupancy
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned WORD         = CPU_WORD,
  parameter int unsigned REG_LOG      = CPU_REG_LOG,
  parameter int unsigned QDEPTH       = RF_WB_QDEPTH,
  parameter int unsigned STARVE_LIMIT = RF_WB_STARVE_LIMIT,
  localparam int unsigned CW          = $clog2(QDEPTH) + 1,
  localparam int unsigned WW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_we,
  input  logic [REG_LOG-1:0]      pipe_rd,
  input  logic [WORD-1:0]         pipe_data,
  input  logic                    md_valid,
  output logic                    md_ready,
  input  logic [REG_LOG-1:0]      md_rd,
  input  logic [WORD-1:0]         md_data,
  output logic                    rf_we,
  output logic [REG_LOG-1:0]      rf_waddr,
  output logic [WORD-1:0]         rf_wdata,
  output logic                    stall_req,
  output logic [(1<<REG_LOG)-1:0] pend_mask,
  output logic [CW-1:0]           q_count
);

  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);
  localparam logic [WW-1:0] LIMIT_C  = WW'(STARVE_LIMIT);

  wb_src_e                 src;
  logic                    md_accept;
  logic                    q_push, q_pop, q_empty, q_full;
  logic [REG_LOG-1:0]      head_rd;
  logic [WORD-1:0]         head_data;
  logic [QDEPTH-1:0]       ent_valid;
  logic [QDEPTH*REG_LOG-1:0] ent_rd;
  logic [WW-1:0]           wait_q, wait_d;
  logic                    stall_q, stall_d;

  wb_result_fifo #(
    .DEPTH (QDEPTH),
    .DW    (WORD),
    .AW    (REG_LOG)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (q_push),
    .push_rd_i   (md_rd),
    .push_data_i (md_data),
    .pop_i       (q_pop),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .count_o     (q_count),
    .empty_o     (q_empty),
    .full_o      (q_full),
    .ent_valid_o (ent_valid),
    .ent_rd_o    (ent_rd)
  );

  assign md_ready  = (q_count < QDEPTH_C);
  assign md_accept = md_valid && md_ready;

  always_comb begin
    src = WB_IDLE;
    if (pipe_we)        src = WB_PIPE;
    else if (!q_empty)  src = WB_QUEUE;
    else if (md_accept) src = WB_BYPASS;
  end

  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (src)
      WB_PIPE:   begin rf_waddr = pipe_rd; rf_wdata = pipe_data; end
      WB_QUEUE:  begin rf_waddr = head_rd; rf_wdata = head_data; end
      WB_BYPASS: begin rf_waddr = md_rd;   rf_wdata = md_data;   end
      default:   ;
    endcase
  end

  // r0 writes are suppressed but still consume the slot, so a queued r0 pops.
  assign rf_we  = (src != WB_IDLE) && (rf_waddr != '0);
  assign q_pop  = (src == WB_QUEUE);
  assign q_push = md_accept && (src != WB_BYPASS);

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (ent_valid[i]) pend_mask[ent_rd[i*REG_LOG +: REG_LOG]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  always_comb begin
    wait_d = wait_q;
    if (q_empty || q_pop)     wait_d = '0;
    else if (wait_q != LIMIT_C) wait_d = wait_q + WW'(1);

    // The pop always removes the head that was starving, so it releases the stall.
    stall_d = stall_q;
    if (q_pop)                   stall_d = 1'b0;
    else if (wait_d == LIMIT_C)  stall_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign stall_req = stall_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [31:0] pend_mask;
  logic [1:0]  q_count;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  rf_wb_arbiter #(
    .WORD         (32),
    .REG_LOG      (5),
    .QDEPTH       (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_rd   (pipe_rd),
    .pipe_data (pipe_data),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_rd     (md_rd),
    .md_data   (md_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .stall_req (stall_req),
    .pend_mask (pend_mask),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every register-file write must match the next expected write.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got r%0d=0x%0h, required no write", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          errors++;
          $display("FAIL rf_write: got r%0d=0x%0h, required r%0d=0x%0h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Apply one cycle of stimulus just after the rising edge, then move to mid-cycle
  // where status outputs are settled and away from both edges.
  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    @(posedge clk);
    #1;
    pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
    md_valid = mv; md_rd = mrd; md_data = md;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    check("reset_q_count",   32'(q_count),   32'd0);
    check("reset_pend_mask", pend_mask,      32'h0);
    check("reset_stall_req", 32'(stall_req), 32'd0);
    check("reset_md_ready",  32'(md_ready),  32'd1);
    check("reset_rf_we",     32'(rf_we),     32'd0);

    // Bypass: empty queue, idle pipe
    expect_wr(5'd7, 32'h1234);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
    check("bypass_rf_we",     32'(rf_we),   32'd1);
    check("bypass_q_count",   32'(q_count), 32'd0);
    check("bypass_pend_mask", pend_mask,    32'h0);
    idle();
    check("bypass_after_q_count", 32'(q_count), 32'd0);

    // Pipe priority while MUL/DIV results queue up
    expect_wr(5'd3, 32'hAAAA);
    drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd5, 32'h5555);
    expect_wr(5'd3, 32'hAAAA);
    drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd6, 32'h6666);
    check("prio_q_count_1", 32'(q_count), 32'd1);
    expect_wr(5'd3, 32'hAAAA);
    drive(1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0, 32'h0);
    check("prio_q_count_full", 32'(q_count),  32'd2);
    check("prio_md_ready",     32'(md_ready), 32'd0);
    check("prio_pend_mask",    pend_mask,     32'h60);
    expect_wr(5'd5, 32'h5555);
    idle();
    check("drain1_pend_mask", pend_mask, 32'h60);
    expect_wr(5'd6, 32'h6666);
    idle();
    check("drain2_q_count",   32'(q_count), 32'd1);
    check("drain2_pend_mask", pend_mask,    32'h40);
    idle();
    check("drain_done_q_count",   32'(q_count), 32'd0);
    check("drain_done_pend_mask", pend_mask,    32'h0);
    check("drain_done_rf_we",     32'(rf_we),   32'd0);

    // Simultaneous push and pop
    expect_wr(5'd1, 32'h11);
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
    expect_wr(5'd9, 32'h99);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hAA0);
    check("pushpop_md_ready", 32'(md_ready), 32'd1);
    expect_wr(5'd10, 32'hAA0);
    idle();
    check("pushpop_q_count",   32'(q_count), 32'd1);
    check("pushpop_pend_mask", pend_mask,    32'h400);
    idle();
    check("pushpop_done_q_count", 32'(q_count), 32'd0);

    // r0 queued behind a pipe write
    expect_wr(5'd2, 32'h22);
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd0, 32'hDEAD);
    idle();
    check("r0_q_count",   32'(q_count), 32'd1);
    check("r0_pend_mask", pend_mask,    32'h0);
    check("r0_rf_we",     32'(rf_we),   32'd0);
    idle();
    check("r0_popped_q_count", 32'(q_count), 32'd0);

    // Starvation: one entry held off by a busy pipe
    expect_wr(5'd4, 32'h44);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd8, 32'h88);
    for (int i = 0; i < 4; i++) begin
      expect_wr(5'd4, 32'h44);
      drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
      check("starve_wait_stall_req", 32'(stall_req), 32'd0);
    end
    expect_wr(5'd8, 32'h88);
    idle();
    check("starve_stall_req",  32'(stall_req), 32'd1);
    check("starve_pend_mask",  pend_mask,      32'h100);
    idle();
    check("starve_cleared_stall_req", 32'(stall_req), 32'd0);
    check("starve_cleared_q_count",   32'(q_count),   32'd0);

    // Reset with a full queue and stall_req high
    expect_wr(5'd4, 32'h44);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd11, 32'hB0B);
    expect_wr(5'd4, 32'h44);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hC0C);
    for (int i = 0; i < 3; i++) begin
      expect_wr(5'd4, 32'h44);
      drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    end
    idle();
    rst = 1'b1;
    check("prerst_stall_req", 32'(stall_req), 32'd1);
    check("prerst_q_count",   32'(q_count),   32'd2);
    check("prerst_pend_mask", pend_mask,      32'h1800);
    @(posedge clk);
    #1 rst = 1'b0;
    #2;
    check("postrst_q_count",   32'(q_count),   32'd0);
    check("postrst_pend_mask", pend_mask,      32'h0);
    check("postrst_stall_req", 32'(stall_req), 32'd0);
    check("postrst_md_ready",  32'(md_ready),  32'd1);
    check("postrst_rf_we",     32'(rf_we),     32'd0);

    idle();
    idle();
    check("all_writes_seen", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline WB stage and the multi-cycle MUL/DIV unit.
- The pipeline WB always has priority and is never back-pressured.
- MUL/DIV results are buffered in a small in-order queue and drained in idle WB cycles.
- Exposes a pending-destination mask for decode hazard checks and a starvation stall request to the pipeline front end.

Parameters:
- WORD, 32, data width.
- REG_LOG, 5, register index width (32 GPRs; r0 hardwired zero).
- QDEPTH, 2, MUL/DIV result queue depth (power of 2, ≥2).
- STARVE_LIMIT, 4, cycles a queued head may wait before stall_req asserts (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pipe_we  in  1  pipeline WB write enable
- pipe_rd  in  REG_LOG  pipeline WB destination
- pipe_data  in  WORD  pipeline WB data
- md_valid  in  1  MUL/DIV result valid
- md_ready  out  1  arbiter can accept a MUL/DIV result
- md_rd  in  REG_LOG  MUL/DIV destination
- md_data  in  WORD  MUL/DIV result
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_LOG  register-file write address
- rf_wdata  out  WORD  register-file write data
- stall_req  out  1  request to freeze the pipeline front end
- pend_mask  out  32  bit i set ⇒ a queued MUL/DIV result targets ri
- q_count  out  clog2(QDEPTH)+1  current queue occupancy

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: queue empty, q_count=0, pend_mask=0, stall_req=0, wait counter=0, md_ready=1.
- Write-port outputs are combinational; there is no reset value for rf_* beyond the resulting rf_we=0 when the pipe is idle and the queue is empty.
- md_ready = (q_count < QDEPTH). It depends only on registered state; there is no pop-through path when full.
- Handshake: a result is accepted when md_valid && md_ready on a rising edge. The MUL/DIV unit holds md_* stable while md_valid && !md_ready.
- Write-port select, priority order:
  1. pipe_we=1 → rf_waddr/rf_wdata = pipe_rd/pipe_data.
  2. Else if queue non-empty → drive the head entry and pop it at the edge.
  3. Else if md_valid (accepted, queue empty) → bypass: drive md_rd/md_data, no enqueue.
  4. Else idle, rf_we=0.
- Accepted-but-not-written results (pipe busy, or queue non-empty) enqueue at the tail. Queue order is strictly FIFO.
- In the same cycle, pop of the head and push of a new entry are both allowed; q_count is unchanged.
- r0: rf_we is forced to 0 whenever the selected address is 0. A queued r0 entry still pops normally. pend_mask[0] is always 0.
- pend_mask = OR over valid queue entries of onehot(rd). It is registered-state derived, and bypassed results never appear in it.
- Decode stalls on pend_mask hits. The arbiter performs no rd-ordering check between the pipe and the queue.
- Wait counter:
  - Increments each cycle the queue is non-empty and no pop occurs.
  - Clears on pop or when the queue is empty.
  - Saturates at STARVE_LIMIT.
- stall_req is a register. It sets on the edge where the wait counter reaches STARVE_LIMIT and clears on the edge of the pop that removes the starving head.
- Pipeline contract: while stall_req=1, pipe_we=0 from the next cycle on. If violated, the pipe still wins and stall_req stays high.
- rst mid-operation discards all queued results; the MUL/DIV unit is reset by the same rst.

Decomposition:
- Shared parameter header (existing CPU parameter include) holds WORD, REG_LOG and GPR count.
- Add RF_WB_QDEPTH and RF_WB_STARVE_LIMIT defaults there.
- One sub-module, wb_result_fifo: QDEPTH-entry FIFO of {rd, data} with push, pop, count, and per-entry valid/rd taps for pend_mask.
- Arbitration mux, bypass, r0 gating and the starvation counter live in the top module.

Test Plan:
- Bypass: idle pipe, md_valid=1, md_rd=7, md_data=0x1234 → same cycle rf_we=1, rf_waddr=7, rf_wdata=0x1234; q_count stays 0; pend_mask=0.
- Priority and queue:
  - Stimulus: pipe_we=1 (rd=3, 0xAAAA) for 3 cycles while md delivers rd=5 then rd=6.
  - Required: rf writes r3 ×3; q_count reaches 2; md_ready=0; pend_mask=0x60.
  - After pipe idles: r5 then r6 written on consecutive cycles; pend_mask returns to 0.
- Simultaneous push/pop: queue holds rd=9, pipe idle, new md rd=10 accepted → r9 written, q_count stays 1, pend_mask=0x400.
- r0 handling: md_rd=0 queued behind a pipe write → pops with rf_we=0; pend_mask bit0 never set.
- Starvation (STARVE_LIMIT=4): one entry queued, pipe_we=1 continuously → stall_req rises after 4 wait cycles.
  - Drop pipe_we the next cycle → entry written that cycle; stall_req clears on the following edge.
- Reset mid-operation: queue full with stall_req=1, assert rst one cycle → q_count=0, pend_mask=0, stall_req=0, md_ready=1 after the edge.
